// File: rtl/ext_mem_burst_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ext_mem_burst_arbiter_pkg : shared codes for the frame-buffer burst arbiter
// Revision : 1.0
// ------------------------------------------------------------------
package ext_mem_burst_arbiter_pkg;

  localparam int LEN_W   = 5;
  localparam int NUM_REQ = 3;

  typedef logic [1:0] arb_state_t;
  typedef logic [1:0] req_idx_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_CMD  = 2'd1;
  localparam arb_state_t ARB_RD   = 2'd2;
  localparam arb_state_t ARB_WR   = 2'd3;

  localparam req_idx_t REQ_INTER = 2'd0;
  localparam req_idx_t REQ_DISP  = 2'd1;
  localparam req_idx_t REQ_RECON = 2'd2;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    return 3'b001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_arb_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ext_mem_arb_pick : display-first, then round-robin inter-pred/recon pick
// Revision : 1.0
// ------------------------------------------------------------------
module ext_mem_arb_pick
  import ext_mem_burst_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_burst,
  input  req_idx_t           rr_last,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           grant_idx
);

  always_comb begin
    grant_idx = REQ_DISP;
    if (req_burst[REQ_DISP]) begin
      grant_idx = REQ_DISP;
    end else if (req_burst[REQ_INTER] && req_burst[REQ_RECON]) begin
      // Contention between R0 and R2 alternates away from the last winner
      grant_idx = (rr_last == REQ_RECON) ? REQ_INTER : REQ_RECON;
    end else if (req_burst[REQ_INTER]) begin
      grant_idx = REQ_INTER;
    end else if (req_burst[REQ_RECON]) begin
      grant_idx = REQ_RECON;
    end
    grant = (|req_burst) ? idx_to_onehot(grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/ext_mem_burst_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ext_mem_burst_arbiter : shares the DDR burst port between three requesters
// Revision : 1.0
// ------------------------------------------------------------------
module ext_mem_burst_arbiter
  import ext_mem_burst_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_REQ-1:0]  req_burst,
  input  logic [NUM_REQ-1:0]  req_rd,
  input  logic [LEN_W-1:0]    req_len_minus1_0,
  input  logic [LEN_W-1:0]    req_len_minus1_1,
  input  logic [LEN_W-1:0]    req_len_minus1_2,
  input  logic [ADDR_W-1:0]   req_addr_0,
  input  logic [ADDR_W-1:0]   req_addr_1,
  input  logic [ADDR_W-1:0]   req_addr_2,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic [NUM_REQ-1:0]  req_valid,
  output logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_next,
  output logic                mem_burst,
  output logic [LEN_W-1:0]    mem_burst_len_minus1,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic                mem_ready,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                mem_wr_next
);

  arb_state_t           state_q, state_d;
  req_idx_t             owner_q, owner_d;
  req_idx_t             rr_last_q, rr_last_d;
  logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 mem_burst_q, mem_burst_d;
  logic [LEN_W-1:0]     mem_len_q, mem_len_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d;

  logic [NUM_REQ-1:0]   grant;
  req_idx_t             grant_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [LEN_W-1:0]     sel_len;

  ext_mem_arb_pick u_pick (
    .req_burst (req_burst),
    .rr_last   (rr_last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_INTER;
      rr_last_q   <= REQ_RECON;
      beat_cnt_q  <= '0;
      req_ready_q <= '0;
      mem_burst_q <= 1'b0;
      mem_len_q   <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      beat_cnt_q  <= beat_cnt_d;
      req_ready_q <= req_ready_d;
      mem_burst_q <= mem_burst_d;
      mem_len_q   <= mem_len_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
    end
  end

  always_comb begin
    case (grant_idx)
      REQ_DISP:  begin sel_addr = req_addr_1; sel_len = req_len_minus1_1; end
      REQ_RECON: begin sel_addr = req_addr_2; sel_len = req_len_minus1_2; end
      default:   begin sel_addr = req_addr_0; sel_len = req_len_minus1_0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready_d = req_ready_q;
    mem_burst_d = mem_burst_q;
    mem_len_d   = mem_len_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    if (ena) begin
      req_ready_d = '0;
      case (state_q)
        ARB_IDLE: begin
          if (|req_burst) begin
            state_d     = ARB_CMD;
            owner_d     = grant_idx;
            req_ready_d = grant;
            mem_burst_d = 1'b1;
            mem_addr_d  = sel_addr;
            mem_len_d   = sel_len;
            // The recon writer only ever writes, whatever req_rd claims
            mem_rd_d    = (grant_idx == REQ_RECON) ? 1'b0 : req_rd[grant_idx];
            if (grant_idx != REQ_DISP) rr_last_d = grant_idx;
          end
        end
        ARB_CMD: begin
          if (mem_ready) begin
            mem_burst_d = 1'b0;
            beat_cnt_d  = mem_len_q;
            state_d     = mem_rd_q ? ARB_RD : ARB_WR;
          end
        end
        ARB_RD: begin
          if (mem_valid) begin
            if (beat_cnt_q == '0) state_d = ARB_IDLE;
            else                  beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
        ARB_WR: begin
          if (mem_wr_next) begin
            if (beat_cnt_q == '0) state_d = ARB_IDLE;
            else                  beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready            = req_ready_q;
    // Gated so the controller cannot accept a command the frozen FSM would miss
    mem_burst            = mem_burst_q & ena;
    mem_burst_len_minus1 = mem_len_q;
    mem_addr             = mem_addr_q;
    mem_rd               = mem_rd_q;
    req_valid            = '0;
    req_data             = '0;
    wr_next              = 1'b0;
    mem_wr_data          = '0;
    if (ena && state_q == ARB_RD) begin
      req_data = mem_data;
      if (mem_valid) req_valid = idx_to_onehot(owner_q);
    end
    if (ena && state_q == ARB_WR) wr_next = mem_wr_next;
    if (ena && owner_q == REQ_RECON) mem_wr_data = wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_burst_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_ext_mem_burst_arbiter : directed self-checking bench for the burst arbiter
// Revision : 1.0
// ------------------------------------------------------------------
module tb_ext_mem_burst_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [2:0]        req_burst;
  logic [2:0]        req_rd;
  logic [4:0]        len0, len1, len2;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [2:0]        req_ready;
  logic [2:0]        req_valid;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] wr_data;
  logic              wr_next;
  logic              mem_burst;
  logic [4:0]        mem_burst_len_minus1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_ready;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr_next;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_mem_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ena                  (ena),
    .req_burst            (req_burst),
    .req_rd               (req_rd),
    .req_len_minus1_0     (len0),
    .req_len_minus1_1     (len1),
    .req_len_minus1_2     (len2),
    .req_addr_0           (addr0),
    .req_addr_1           (addr1),
    .req_addr_2           (addr2),
    .req_ready            (req_ready),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .wr_data              (wr_data),
    .wr_next              (wr_next),
    .mem_burst            (mem_burst),
    .mem_burst_len_minus1 (mem_burst_len_minus1),
    .mem_addr             (mem_addr),
    .mem_rd               (mem_rd),
    .mem_wr_data          (mem_wr_data),
    .mem_ready            (mem_ready),
    .mem_valid            (mem_valid),
    .mem_data             (mem_data),
    .mem_wr_next          (mem_wr_next)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one full burst from IDLE: grant, command accept, then every beat back-to-back.
  task automatic serve(input int idx, input logic [15:0] addr, input logic [4:0] len,
                       input logic exp_rd, input logic [2:0] re_mask);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    tick();
    chk("grant_ready", req_ready, oh);
    chk("cmd_burst", mem_burst, 1);
    chk("cmd_addr", mem_addr, addr);
    chk("cmd_len", mem_burst_len_minus1, len);
    chk("cmd_rd", mem_rd, exp_rd);
    req_burst = (req_burst & ~oh) | re_mask;
    mem_ready = 1'b1;
    tick();
    chk("ready_pulse_end", req_ready, 0);
    chk("cmd_burst_end", mem_burst, 0);
    for (int b = 0; b <= int'(len); b++) begin
      if (exp_rd) begin
        mem_valid = 1'b1;
        mem_data  = 16'hD000 + 16'(idx * 256) + 16'(b);
        #1;
        chk("rd_valid", req_valid, oh);
        chk("rd_data", req_data, mem_data);
      end else begin
        mem_wr_next = 1'b1;
        wr_data     = 16'hC000 + 16'(b);
        #1;
        chk("wr_next", wr_next, 1);
        chk("wr_data", mem_wr_data, wr_data);
      end
      tick();
    end
    mem_valid   = 1'b0;
    mem_wr_next = 1'b0;
  endtask

  initial begin
    int cnt;
    int pulses;
    rst_n = 1'b0; ena = 1'b1; req_burst = '0; req_rd = '0;
    len0 = '0; len1 = '0; len2 = '0; addr0 = '0; addr1 = '0; addr2 = '0;
    wr_data = '0; mem_ready = 1'b1; mem_valid = 1'b0; mem_data = '0; mem_wr_next = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_wr_next", wr_next, 0);
    chk("rst_mem_burst", mem_burst, 0);
    chk("rst_mem_len", mem_burst_len_minus1, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 1);
    rst_n = 1'b1;

    // 1: lone R0 read of 4 beats
    req_burst = 3'b001; req_rd = 3'b001; len0 = 5'd3; addr0 = 16'h0100;
    serve(0, 16'h0100, 5'd3, 1'b1, 3'b000);
    mem_valid = 1'b1;
    #1;
    chk("t1_idle_ignores_valid", req_valid, 0);
    mem_valid = 1'b0;

    // 2: three-way contention from rr_last=R2, R2 claims read but must write
    do_reset();
    req_burst = 3'b111; req_rd = 3'b111;
    len0 = 5'd0; len1 = 5'd0; len2 = 5'd0;
    addr0 = 16'h0200; addr1 = 16'h0300; addr2 = 16'h0400;
    serve(1, 16'h0300, 5'd0, 1'b1, 3'b000);
    serve(0, 16'h0200, 5'd0, 1'b1, 3'b010);
    serve(1, 16'h0300, 5'd0, 1'b1, 3'b000);
    serve(2, 16'h0400, 5'd0, 1'b0, 3'b000);
    tick();
    chk("t2_idle_no_grant", req_ready, 0);

    // 3: R2 single-beat write with mem_ready low for 5 cycles
    req_rd = 3'b000; len2 = 5'd0; addr2 = 16'h0480;
    mem_ready = 1'b0;
    req_burst = 3'b100;
    tick();
    chk("t3_grant", req_ready, 3'b100);
    req_burst = 3'b000;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) mem_ready = 1'b1;
      #1;
      if (mem_burst) cnt++;
      tick();
    end
    chk("t3_burst_cycles", cnt, 5);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      mem_wr_next = 1'b1;
      wr_data     = 16'hBEE0 + 16'(c);
      #1;
      if (wr_next) pulses++;
      if (c == 0) chk("t3_wr_data", mem_wr_data, 16'hBEE0);
      tick();
    end
    mem_wr_next = 1'b0;
    chk("t3_wr_pulses", pulses, 1);

    // 4: reset during the 3rd of 8 read beats
    req_rd = 3'b001; len0 = 5'd7; addr0 = 16'h0600;
    req_burst = 3'b001;
    tick();
    chk("t4_grant", req_ready, 3'b001);
    req_burst = 3'b000;
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_data  = 16'h4400 + 16'(b);
      #1;
      chk("t4_pre_valid", req_valid, 3'b001);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t4_rst_valid", req_valid, 0);
    chk("t4_rst_data", req_data, 0);
    chk("t4_rst_addr", mem_addr, 0);
    chk("t4_rst_len", mem_burst_len_minus1, 0);
    chk("t4_rst_rd", mem_rd, 1);
    chk("t4_rst_burst", mem_burst, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk("t4_post_valid", req_valid, 0);
    end
    mem_valid = 1'b0;

    // 5: ena low for 4 cycles mid-read, burst then completes
    len0 = 5'd3; addr0 = 16'h0500;
    req_burst = 3'b001;
    tick();
    chk("t5_grant", req_ready, 3'b001);
    req_burst = 3'b000;
    tick();
    mem_valid = 1'b1;
    mem_data  = 16'h5500;
    #1;
    chk("t5_beat0", req_valid, 3'b001);
    tick();
    mem_valid = 1'b0;
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t5_frozen_valid", req_valid, 0);
      tick();
    end
    ena = 1'b1;
    for (int b = 1; b < 4; b++) begin
      mem_valid = 1'b1;
      mem_data  = 16'h5500 + 16'(b);
      #1;
      chk("t5_resume_valid", req_valid, 3'b001);
      chk("t5_resume_data", req_data, mem_data);
      tick();
    end
    #1;
    chk("t5_done_idle", req_valid, 0);
    mem_valid = 1'b0;

    // ena low in IDLE suppresses arbitration
    ena = 1'b0;
    req_burst = 3'b001;
    tick();
    chk("ena_low_no_grant", req_ready, 0);
    chk("ena_low_no_burst", mem_burst, 0);
    req_burst = 3'b000;
    ena = 1'b1;
    tick();

    // 6: maximum 32-beat read, 33rd beat ignored
    len0 = 5'd31; addr0 = 16'h0700;
    req_burst = 3'b001;
    serve(0, 16'h0700, 5'd31, 1'b1, 3'b000);
    mem_valid = 1'b1;
    #1;
    chk("t6_beat33_ignored", req_valid, 0);
    mem_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
